mod_counter: RTL and testbench

//  Parametrised modulo up/down counter with prescaler, synchronous load, and free-run or one-shot mode.

---
 rtl/counter_pkg.sv | 15 +
 rtl/mod_counter_tick_prescaler.sv | 38 +++
 rtl/mod_counter.sv | 115 +++++++++++
 tb/tb_mod_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and encodings for the modulo counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// Prescaler: one tick every DIV enabled cycles; the counter wraps to 0 on tick and clears on clr.
module tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic next,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign tick = en & (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge next) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, load, free-run/one-shot modes and registered tc pulse.
// Optional MOD_COUNTER_CASCADE_EN adds cin/cout for zero-lag chaining.
//   state | meaning
//   IDLE  | after reset, count holds until start
//   RUN   | counting on each prescaled tick
//   DONE  | one-shot finished, count holds at terminal
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 9,
    parameter int DIV   = 1
) (
    input  logic             next,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_CASCADE_EN
    input  logic             cin,
    output logic             cout,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;

    logic             cin_w;
    logic             running;
    logic             tick;
    logic             at_term;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] restart_val;
    logic [WIDTH-1:0] load_clamped;

`ifdef MOD_COUNTER_CASCADE_EN
    assign cin_w = cin;
`else
    assign cin_w = 1'b1;
`endif

    assign running      = (state_q == RUN);
    assign terminal     = (dir == DIR_DOWN) ? '0 : MAX_V;
    assign restart_val  = (dir == DIR_DOWN) ? MAX_V : '0;
    assign at_term      = (count_q == terminal);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Prescaler only advances while running, so tick already implies RUN and cin.
    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .next (next),
        .rst  (rst),
        .en   (en & cin_w & running),
        .clr  (start | load),
        .tick (tick)
    );

`ifdef MOD_COUNTER_CASCADE_EN
    assign cout = tick & cin & at_term & running;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (start) begin
            state_d = RUN;
            count_d = restart_val;
        end else if (running && tick) begin
            if (at_term) begin
                tc_d = 1'b1;
                if (mode == MODE_FREE) begin
                    count_d = restart_val;
                end else begin
                    state_d = DONE;
                end
            end else if (dir == DIR_UP) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge next) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: behavioural model plus directed literal checks.
module tb_mod_counter;

    logic next = 1'b0;
    always #5 next = ~next;

    logic       rst = 1'b0, en = 1'b0, start = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count1, count3;
    logic       tc1, busy1, tc3, busy3;
    logic       chk_en = 1'b0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

`ifdef MOD_COUNTER_CASCADE_EN
    logic       cout1, cout3;
    logic       c_start = 1'b0;
    logic [3:0] c_lo, c_hi;
    logic       c_lo_tc, c_hi_tc, c_lo_busy, c_hi_busy, c_lo_cout, c_hi_cout;

    mod_counter #(.WIDTH(4), .MAX(9), .DIV(1)) dut1 (
        .next(next), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .cin(1'b1), .cout(cout1),
        .count(count1), .tc(tc1), .busy(busy1));
    mod_counter #(.WIDTH(4), .MAX(9), .DIV(3)) dut3 (
        .next(next), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .cin(1'b1), .cout(cout3),
        .count(count3), .tc(tc3), .busy(busy3));
    mod_counter #(.WIDTH(4), .MAX(9), .DIV(1)) dut_lo (
        .next(next), .rst(rst), .en(1'b1), .start(c_start), .mode(1'b0), .dir(1'b0),
        .load(1'b0), .load_val(4'd0), .cin(1'b1), .cout(c_lo_cout),
        .count(c_lo), .tc(c_lo_tc), .busy(c_lo_busy));
    mod_counter #(.WIDTH(4), .MAX(9), .DIV(1)) dut_hi (
        .next(next), .rst(rst), .en(1'b1), .start(c_start), .mode(1'b0), .dir(1'b0),
        .load(1'b0), .load_val(4'd0), .cin(c_lo_cout), .cout(c_hi_cout),
        .count(c_hi), .tc(c_hi_tc), .busy(c_hi_busy));

    // Cascade reference: the pair is a single decimal number 0..99.
    int c_v = 0;
    bit c_active = 1'b0;
    always @(posedge next) begin
        if (rst) c_active = 1'b0;
        else if (c_start) begin c_v = 0; c_active = 1'b1; end
        else if (c_active) c_v = (c_v + 1) % 100;
    end
    always @(negedge next) begin
        if (c_active) check("cascade_value", int'(c_hi) * 10 + int'(c_lo), c_v);
    end
`else
    mod_counter #(.WIDTH(4), .MAX(9), .DIV(1)) dut1 (
        .next(next), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val),
        .count(count1), .tc(tc1), .busy(busy1));
    mod_counter #(.WIDTH(4), .MAX(9), .DIV(3)) dut3 (
        .next(next), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val),
        .count(count3), .tc(tc3), .busy(busy3));
`endif

    // Reference model: index 0 is the DIV=1 instance, index 1 the DIV=3 instance.
    int m_cnt[2];
    int m_pre[2];
    bit m_run[2];
    bit m_tc[2];
    int divs[2] = '{1, 3};

    always @(posedge next) begin
        for (int k = 0; k < 2; k++) begin
            int term;
            int first;
            term  = dir ? 0 : 9;
            first = dir ? 9 : 0;
            m_tc[k] = 1'b0;
            if (rst) begin
                m_run[k] = 1'b0;
                m_cnt[k] = 0;
                m_pre[k] = 0;
            end else if (load) begin
                m_cnt[k] = (int'(load_val) > 9) ? 9 : int'(load_val);
                m_pre[k] = 0;
            end else if (start) begin
                m_run[k] = 1'b1;
                m_cnt[k] = first;
                m_pre[k] = 0;
            end else if (m_run[k] && en) begin
                if (m_pre[k] == divs[k] - 1) begin
                    m_pre[k] = 0;
                    if (m_cnt[k] == term) begin
                        m_tc[k] = 1'b1;
                        if (mode) m_run[k] = 1'b0;
                        else      m_cnt[k] = first;
                    end else begin
                        m_cnt[k] = m_cnt[k] + (dir ? -1 : 1);
                    end
                end else begin
                    m_pre[k] = m_pre[k] + 1;
                end
            end
        end
    end

    always @(negedge next) begin
        if (chk_en) begin
            check("m_count_div1", count1, m_cnt[0]);
            check("m_tc_div1",    tc1,    m_tc[0]);
            check("m_busy_div1",  busy1,  m_run[0]);
            check("m_count_div3", count3, m_cnt[1]);
            check("m_tc_div3",    tc3,    m_tc[1]);
            check("m_busy_div3",  busy3,  m_run[1]);
        end
    end

    initial begin
        // Reset held for two edges, then idle with no start.
        rst = 1'b1; en = 1'b1;
        repeat (2) @(negedge next);
        rst = 1'b0; chk_en = 1'b1;
        @(negedge next);
        check("rst_count", count1, 0);
        check("rst_tc", tc1, 0);
        check("rst_busy", busy1, 0);
        repeat (3) @(negedge next);
        check("idle_hold_count", count1, 0);
        check("idle_hold_busy", busy3, 0);

        // Free-run up count with wrap.
        mode = 1'b0; dir = 1'b0; start = 1'b1;
        @(negedge next); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("up_seq", count1, i % 10);
            check("up_tc", tc1, (i == 10) ? 1 : 0);
            check("up_busy", busy1, 1);
            @(negedge next);
        end

        // One-shot down count, then restart.
        mode = 1'b1; dir = 1'b1; start = 1'b1;
        @(negedge next); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("down_seq", count1, (i <= 9) ? 9 - i : 0);
            check("down_tc", tc1, (i == 10) ? 1 : 0);
            check("down_busy", busy1, (i <= 9) ? 1 : 0);
            @(negedge next);
        end
        start = 1'b1;
        @(negedge next); start = 1'b0;
        check("restart_count", count1, 9);
        check("restart_busy", busy1, 1);

        // DIV=3 stepping and enable freeze.
        mode = 1'b0; dir = 1'b0; start = 1'b1;
        @(negedge next); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("div3_seq", count3, i / 3);
            @(negedge next);
        end
        en = 1'b0;
        repeat (5) begin
            @(negedge next);
            check("div3_freeze", count3, 2);
        end
        en = 1'b1;
        @(negedge next);
        check("div3_resume_a", count3, 2);
        @(negedge next);
        check("div3_resume_b", count3, 3);

        // Direction change mid-run.
        dir = 1'b1;
        repeat (8) @(negedge next);
        dir = 1'b0;
        repeat (4) @(negedge next);

        // Load clamp, load beats start, reset mid-run.
        start = 1'b1;
        @(negedge next); start = 1'b0;
        repeat (3) @(negedge next);
        load_val = 4'd13; load = 1'b1;
        @(negedge next);
        check("load_clamp", count1, 9);
        check("load_keeps_busy", busy1, 1);
        load_val = 4'd4; start = 1'b1; dir = 1'b1;
        @(negedge next); load = 1'b0; start = 1'b0;
        check("load_wins", count1, 4);
        check("load_wins_div3", count3, 4);
        repeat (2) @(negedge next);
        rst = 1'b1;
        @(negedge next); rst = 1'b0;
        check("midrun_rst_count", count1, 0);
        check("midrun_rst_busy", busy1, 0);
        check("midrun_rst_tc", tc1, 0);
        check("midrun_rst_busy3", busy3, 0);

        // Load while idle stays idle.
        load_val = 4'd7; load = 1'b1;
        @(negedge next); load = 1'b0;
        check("idle_load_count", count1, 7);
        check("idle_load_busy", busy1, 0);
        repeat (3) @(negedge next);
        check("idle_load_hold", count1, 7);

`ifdef MOD_COUNTER_CASCADE_EN
        c_start = 1'b1;
        @(negedge next); c_start = 1'b0;
        repeat (10) @(negedge next);
        check("cascade_hi_at10", c_hi, 1);
        check("cascade_lo_at10", c_lo, 0);
        repeat (90) @(negedge next);
        check("cascade_hi_wrap", c_hi, 0);
        check("cascade_hi_tc", c_hi_tc, 1);
        repeat (5) @(negedge next);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
